pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a bubble counter. It is the successor to the fixed decode/execute register: control and data fields are packed into generic buses, and the stage can stall without a combinational ready path. It sits between any two pipeline stages (F/D, D/E, E/M, M/W), with hazard logic driving `flush` and downstream readiness driving `out_ready`.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_sat_counter.sv | 31 +++
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 tb/tb_pipe_stage_skid.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CTRL_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_r;

    // Count requested cycles, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating bubble counter. All handshake outputs are flops.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH          = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH          = DEF_CTRL_WIDTH,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
    parameter int CNT_WIDTH           = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    pipe_state_e           state_r;
    logic [CTRL_WIDTH-1:0] main_ctrl_r;
    logic [DATA_WIDTH-1:0] main_data_r;
    logic [CTRL_WIDTH-1:0] skid_ctrl_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic                  accept_s;
    logic                  xfer_s;

    assign accept_s = in_valid & in_ready_r;
    assign xfer_s   = out_valid_r & out_ready;

    // State machine and storage; in_ready/out_valid flops track the next state directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= {CTRL_WIDTH{1'b0}};
            main_data_r <= {DATA_WIDTH{1'b0}};
            skid_ctrl_r <= {CTRL_WIDTH{1'b0}};
            skid_data_r <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= {CTRL_WIDTH{1'b0}};
            skid_ctrl_r <= {CTRL_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data_r <= {DATA_WIDTH{1'b0}};
                skid_data_r <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_ctrl_r <= in_ctrl;
                        main_data_r <= in_data;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept_s && xfer_s) begin
                        main_ctrl_r <= in_ctrl;
                        main_data_r <= in_data;
                    end else if (xfer_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        // Downstream stalled: park the beat so in_ready never depends on out_ready.
                        skid_ctrl_r <= in_ctrl;
                        skid_data_r <= in_data;
                        state_r     <= ST_SKID;
                        in_ready_r  <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (xfer_s) begin
                        main_ctrl_r <= skid_ctrl_r;
                        main_data_r <= skid_data_r;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    pipe_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (~out_valid_r),
        .count(bubble_cnt)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign out_ctrl  = main_ctrl_r & {CTRL_WIDTH{out_valid_r}};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] bubble_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         mq[$];
    logic [DW-1:0] m_last;
    int            m_bub;
    bit            started = 1'b0;
    logic [DW-1:0] out_log[$];

    pipe_stage_skid #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CLEAR_DATA_ON_FLUSH(1'b0), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of at most two beats.
    always @(posedge clk) begin
        beat_t b;
        bit acc, xfr;
        if (!rst_n) begin
            mq.delete();
            m_last = '0;
            m_bub  = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            xfr = (mq.size() > 0) && out_ready;
            if (mq.size() == 0 && m_bub < 15) m_bub++;
            if (flush) begin
                mq.delete();
            end else begin
                if (xfr) void'(mq.pop_front());
                if (acc) begin
                    b.ctrl = in_ctrl;
                    b.data = in_data;
                    mq.push_back(b);
                end
            end
            if (mq.size() > 0) m_last = mq[0].data;
        end
        started = 1'b1;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus a log of beats the DUT hands downstream.
    always @(negedge clk) begin
        if (started) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            chk("m_out_data", out_data, (mq.size() > 0) ? mq[0].data : m_last);
            chk("m_out_ctrl", {16'd0, out_ctrl}, (mq.size() > 0) ? {16'd0, mq[0].ctrl} : 32'd0);
            chk("m_bubble", {28'd0, bubble_cnt}, m_bub);
            if (out_valid && out_ready && !flush && rst_n) out_log.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = 16'hC000 | d[15:0];
    endtask

    initial begin
        logic [NW-1:0] b0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'h55;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ctrl", {16'd0, out_ctrl}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_bubble", {28'd0, bubble_cnt}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'd0);
        tick();

        // Streaming 1..8 with out_ready high.
        out_ready = 1'b1;
        out_log.delete();
        b0 = bubble_cnt;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            tick();
            chk("stream_data", out_data, i);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        chk("stream_bubble_held", {28'd0, bubble_cnt}, {28'd0, b0} + 32'd1);
        drive(1'b0, 32'd0);
        tick(); tick();
        chk("stream_count", out_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) chk("stream_order", out_log[i], i + 1);

        // Skid: A held in main, B captured into skid while stalled, C held off.
        out_ready = 1'b0;
        out_log.delete();
        drive(1'b1, 32'hA); tick();
        drive(1'b1, 32'hB); tick();
        chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_data_a", out_data, 32'hA);
        drive(1'b1, 32'hC); tick();
        chk("skid_hold_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_hold_a", out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("skid_then_b", out_data, 32'hB);
        tick();
        chk("skid_then_c", out_data, 32'hC);
        drive(1'b0, 32'd0);
        tick(); tick();
        chk("skid_count", out_log.size(), 32'd3);
        if (out_log.size() == 3) begin
            chk("skid_ord0", out_log[0], 32'hA);
            chk("skid_ord1", out_log[1], 32'hB);
            chk("skid_ord2", out_log[2], 32'hC);
        end

        // Flush while in SKID with downstream stalled.
        out_ready = 1'b0;
        out_log.delete();
        drive(1'b1, 32'h1A); tick();
        drive(1'b1, 32'h1B); tick();
        drive(1'b0, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fl_skid_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_skid_ctrl", {16'd0, out_ctrl}, 32'd0);
        chk("fl_skid_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_skid_data_kept", out_data, 32'h1A);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("fl_skid_none_out", out_log.size(), 32'd0);

        // Flush while a beat is being accepted.
        drive(1'b1, 32'hD);
        flush = 1'b1; tick(); flush = 1'b0;
        drive(1'b0, 32'd0);
        chk("fl_acc_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("fl_acc_still_empty", {31'd0, out_valid}, 32'd0);
        chk("fl_acc_none_out", out_log.size(), 32'd0);

        // Reset and flush together: reset wins.
        out_ready = 1'b0;
        drive(1'b1, 32'h77); tick();
        drive(1'b0, 32'd0);
        rst_n = 1'b0; flush = 1'b1; tick();
        chk("rf_valid", {31'd0, out_valid}, 32'd0);
        chk("rf_data", out_data, 32'd0);
        chk("rf_bubble", {28'd0, bubble_cnt}, 32'd0);
        chk("rf_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1; flush = 1'b0;

        // Bubble counter saturation, unaffected by flush.
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", {28'd0, bubble_cnt}, 32'd15);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("sat_after_flush", {28'd0, bubble_cnt}, 32'd15);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
